// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Bundle of the CPU write path, FIFO status and uart_tx
//               handshake signals seen by uart_tx_fifo.
//   wr_data/wr_en/flush/ovf_clear : CPU-side controls (into the FIFO)
//   full/empty/level/overflow     : FIFO status (out of the FIFO)
//   tx_data/tx_send               : request to uart_tx (out of the FIFO)
//   tx_ready                      : uart_tx idle/accepting (into the FIFO)
//   modport slave  : the FIFO side
//   modport master : the surroundings (CPU write path plus uart_tx)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  wr_data;
  logic        wr_en;
  logic        flush;
  logic        ovf_clear;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;

  modport slave (
    input  wr_data, wr_en, flush, ovf_clear, tx_ready,
    output full, empty, level, overflow, tx_data, tx_send
  );

  modport master (
    output wr_data, wr_en, flush, ovf_clear, tx_ready,
    input  full, empty, level, overflow, tx_data, tx_send
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO between the CPU I/O-write path and the uart_tx
//               serializer. Bytes are pushed with a one-cycle strobe and
//               drained one at a time over the tx_data/tx_send/tx_ready
//               handshake.
// Ports       : clk      - system clock
//               reset_n  - asynchronous reset, active-low
//               bus      - uart_tx_fifo_if.slave (write path, status,
//                          uart_tx handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          tx_send_q, tx_send_d;
  logic [7:0]    tx_data_q, tx_data_d;
  // Set when a flush hits while a byte is in flight: that byte was already
  // discarded from the level count, so its pop must not happen.
  logic          flushed_q, flushed_d;

  logic          full_w, empty_w, push_w, pop_w, drop_w;

  assign full_w  = (level_q == c_full_level);
  assign empty_w = (level_q == '0);
  assign push_w  = bus.wr_en && !full_w && !bus.flush;
  assign drop_w  = bus.wr_en && full_w;

  // Handshake FSM with registered outputs
  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    flushed_d = flushed_q;
    pop_w     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_send_d = 1'b0;
        flushed_d = 1'b0;
        if (bus.tx_ready && !empty_w) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          flushed_d = bus.flush;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        tx_send_d = 1'b1;
        if (bus.flush) begin
          flushed_d = 1'b1;
        end
        // tx_ready low means uart_tx has latched tx_data and left idle
        if (!bus.tx_ready) begin
          pop_w     = !flushed_q && !bus.flush;
          tx_send_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // tx_ready is stale until uart_tx finishes the frame; wait it out
        tx_send_d = 1'b0;
        if (bus.tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_send_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Pointers, level and overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_w, pop_w})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // A dropped push wins over a same-cycle clear
    if (drop_w) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      flushed_q  <= flushed_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo: a cycle table with a
//               directly driven tx_ready, then directed sequences against a
//               small behavioural uart_tx model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CYCLE = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural uart_tx ----------------
  logic       use_model = 1'b0;
  logic       tb_ready  = 1'b0;
  logic       m_hold    = 1'b0;
  logic       m_ready;
  int         m_st;
  int         m_cnt;
  logic [7:0] rcv[$];

  assign bus.tx_ready = use_model ? (m_ready && !m_hold) : tb_ready;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st    <= 0;
      m_ready <= 1'b1;
      m_cnt   <= 0;
    end else begin
      case (m_st)
        0: if (use_model && !m_hold && bus.tx_send) begin
             rcv.push_back(bus.tx_data);
             m_ready <= 1'b0;
             m_cnt   <= 0;
             m_st    <= 1;
           end
        1: if (m_cnt == 10*CYCLE-1) m_st <= 2;
           else m_cnt <= m_cnt + 1;
        default: if (!bus.tx_send) begin
             m_ready <= 1'b1;
             m_st    <= 0;
           end
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.ovf_clear = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- table ----------------
  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ovf_clr;
    logic       ready;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       send;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[12];

  logic [7:0] expq[$];
  int k;
  int sends;

  initial begin
    //           wr  data  fl cl rdy  lvl   E  F  O  S  data
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[3]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42};
    tbl[8]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42};

    // ---- reset state ----
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.ovf_clear = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {19'd0, bus.level, bus.empty, bus.full, bus.overflow, bus.tx_send, bus.tx_data},
        {19'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    reset_n = 1'b1;
    @(negedge clk);

    // ---- cycle table, tx_ready driven directly ----
    for (int i = 0; i < 12; i++) begin
      bus.wr_en     = tbl[i].wr_en;
      bus.wr_data   = tbl[i].wr_data;
      bus.flush     = tbl[i].flush;
      bus.ovf_clear = tbl[i].ovf_clr;
      tb_ready      = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("table_row%0d", i),
          {15'd0, bus.level, bus.empty, bus.full, bus.overflow, bus.tx_send, bus.tx_data},
          {15'd0, tbl[i].level, tbl[i].empty, tbl[i].full, tbl[i].ovf, tbl[i].send, tbl[i].data});
    end
    bus.wr_en = 1'b0; bus.flush = 1'b0; bus.ovf_clear = 1'b0;

    // ---- single byte latency ----
    use_model = 1'b1;
    do_reset();
    rcv.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'h41;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("lat_N_empty_send", {30'd0, bus.empty, bus.tx_send}, 32'd0);
    @(negedge clk);
    chk("lat_N1_send_data", {23'd0, bus.tx_send, bus.tx_data}, {23'd0, 1'b1, 8'h41});
    @(negedge clk);
    @(negedge clk);
    chk("lat_N3_pop", {26'd0, bus.level, bus.tx_send}, 32'd0);
    k = 0;
    while (!(rcv.size() == 1 && m_st == 0 && bus.tx_ready) && k < 400) begin @(negedge clk); k++; end
    chk("single_done", {31'd0, (rcv.size() == 1)}, 32'd1);
    if (rcv.size() > 0) chk("single_byte", {24'd0, rcv[0]}, 32'h41);

    // ---- fill to full, overflow, drain in order ----
    rcv.delete();
    m_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    chk("full_level", {26'd0, bus.full, bus.level}, {26'd0, 1'b1, 5'd16});
    push(8'hEE);
    chk("ovf_set", {26'd0, bus.overflow, bus.level}, {26'd0, 1'b1, 5'd16});
    bus.ovf_clear = 1'b1;
    @(negedge clk);
    bus.ovf_clear = 1'b0;
    chk("ovf_clear", {31'd0, bus.overflow}, 32'd0);
    m_hold = 1'b0;
    k = 0;
    while (!(rcv.size() >= 16 && bus.level == 0 && m_st == 0 && bus.tx_ready) && k < 16*250) begin
      @(negedge clk); k++;
    end
    repeat (5) @(negedge clk);
    chk("burst_count", rcv.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < rcv.size()) chk($sformatf("burst_byte%0d", i), {24'd0, rcv[i]}, {24'd0, 8'h30 + 8'(i)});
    end

    // ---- push coincident with pop, pointer wrap over 40 bytes ----
    rcv.delete(); expq.delete();
    m_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push(8'h80 + 8'(i));
      expq.push_back(8'h80 + 8'(i));
    end
    m_hold = 1'b0;
    for (int i = 5; i < 40; i++) begin
      k = 0;
      while (!(bus.tx_send && !bus.tx_ready) && k < 400) begin @(negedge clk); k++; end
      chk("pop_cycle_seen", {31'd0, bus.tx_send && !bus.tx_ready}, 32'd1);
      push(8'h80 + 8'(i));
      expq.push_back(8'h80 + 8'(i));
      chk($sformatf("level_hold%0d", i), {27'd0, bus.level}, 32'd5);
    end
    k = 0;
    while (!(rcv.size() >= 40 && bus.level == 0 && m_st == 0 && bus.tx_ready) && k < 10*250) begin
      @(negedge clk); k++;
    end
    chk("wrap_count", rcv.size(), 32'd40);
    for (int i = 0; i < 40; i++) begin
      if (i < rcv.size()) chk($sformatf("wrap_byte%0d", i), {24'd0, rcv[i]}, {24'd0, expq[i]});
    end

    // ---- flush during S_REQ ----
    rcv.delete();
    m_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    m_hold = 1'b0;
    k = 0;
    while (!bus.tx_send && k < 50) begin @(negedge clk); k++; end
    chk("flush_req_seen", {31'd0, bus.tx_send}, 32'd1);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    @(negedge clk);
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    chk("flush_state", {25'd0, bus.level, bus.empty, bus.tx_send}, {25'd0, 5'd0, 1'b1, 1'b1});
    k = 0;
    while (!(rcv.size() >= 1 && m_st == 0 && bus.tx_ready) && k < 400) begin @(negedge clk); k++; end
    sends = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx_send) sends++;
    end
    chk("flush_no_more_send", sends, 32'd0);
    chk("flush_level", {26'd0, bus.empty, bus.level}, {26'd0, 1'b1, 5'd0});
    chk("flush_count", rcv.size(), 32'd1);
    if (rcv.size() > 0) chk("flush_byte", {24'd0, rcv[0]}, 32'hA0);

    // ---- reset mid-frame ----
    rcv.delete();
    push(8'h11);
    k = 0;
    while (!bus.tx_send && k < 50) begin @(negedge clk); k++; end
    chk("rst_req_seen", {31'd0, bus.tx_send}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async", {26'd0, bus.tx_send, bus.level}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rcv.delete();
    push(8'h5A);
    k = 0;
    while (!(rcv.size() >= 1 && bus.level == 0 && m_st == 0 && bus.tx_ready) && k < 400) begin
      @(negedge clk); k++;
    end
    chk("post_rst_count", rcv.size(), 32'd1);
    if (rcv.size() > 0) chk("post_rst_byte", {24'd0, rcv[0]}, 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
